// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and instruction layout shared by the ALU sequencer.
package alu_pkg;
  localparam logic [3:0] OP_HALT  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_LOADI = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_CMP   = 4'd10;
  localparam logic [3:0] OP_NOT   = 4'd13;
  localparam logic [3:0] OP_NOR   = 4'd15;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_DONE} state_e;

  // Field order fixes the bit positions: op[15:12] rd[11:8] rs1[7:4] rs2[3:0].
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } instr_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_CMP, OP_NOT, OP_NOR};
  endfunction
endpackage

// File: rtl/seq_regfile.sv
// seq_regfile: 16x32 register file, two read ports plus debug read, one write port, r0 reads zero.
module seq_regfile
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [3:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  logic [31:0] mem_q [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
    end else if (we && waddr != 4'd0) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a  = (raddr_a == 4'd0) ? '0 : mem_q[raddr_a];
  assign rdata_b  = (raddr_b == 4'd0) ? '0 : mem_q[raddr_b];
  assign dbg_data = (dbg_addr == 4'd0) ? '0 : mem_q[dbg_addr];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches instructions from a synchronous ROM and drives an external
// combinational ALU, writing results back into a 16-entry register file.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            rom_en,
  output logic [PC_W-1:0] rom_addr,
  input  logic [15:0]     rom_data,
  output logic [3:0]      alu_op,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  input  logic [31:0]     alu_out,
  input  logic            alu_carry,
  output logic            carry_flag,
  input  logic [3:0]      dbg_addr,
  output logic [31:0]     dbg_data
);
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  instr_t          ir_q, ir_d, inst;
  logic            err_q, err_d, carry_q, carry_d, we, exec;
  logic [3:0]      waddr;
  logic [31:0]     wdata, rs1_data, rs2_data;

  assign inst = instr_t'(rom_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    err_d   = err_q;
    carry_d = carry_q;
    we      = 1'b0;
    waddr   = ir_q.rd;
    wdata   = alu_out;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        pc_d    = '0;
        err_d   = 1'b0;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = inst;
        pc_d = pc_q + PC_W'(1);
        // LOADI retires here; unsupported opcodes only flag the error and move on.
        if (inst.op == OP_HALT) state_d = S_DONE;
        else if (is_alu_op(inst.op)) state_d = S_EXEC;
        else begin
          state_d = S_FETCH;
          we      = inst.op == OP_LOADI;
          waddr   = inst.rd;
          wdata   = {24'b0, inst.rs1, inst.rs2};
          err_d   = err_q | (inst.op != OP_LOADI);
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        we      = 1'b1;
        carry_d = (ir_q.op == OP_ADD || ir_q.op == OP_SUB) ? alu_carry : carry_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  seq_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (ir_q.rs1),
    .rdata_a  (rs1_data),
    .raddr_b  (ir_q.rs2),
    .rdata_b  (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign exec       = state_q == S_EXEC;
  assign busy       = state_q != S_IDLE;
  assign done       = state_q == S_DONE;
  assign rom_en     = state_q == S_FETCH;
  assign rom_addr   = rom_en ? pc_q : '0;
  assign alu_op     = exec ? ir_q.op : 4'd0;
  assign alu_a      = exec ? rs1_data : '0;
  assign alu_b      = exec ? rs2_data : '0;
  assign err        = err_q;
  assign carry_flag = carry_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed programs against a behavioural ROM and ALU.
module tb_alu_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        busy, done, err, rom_en, alu_carry, carry_flag;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data = 16'h0;
  logic [3:0]  alu_op, dbg_addr = 4'd0;
  logic [31:0] alu_a, alu_b, alu_out, dbg_data;
  logic [15:0] rom [256];
  int          n_checks = 0, n_fail = 0;

  alu_sequencer #(.PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_carry(alu_carry),
    .carry_flag(carry_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  // Reference ALU: SUB carry means no borrow; logic ops report carry 0.
  always_comb begin
    {alu_carry, alu_out} = 33'd0;
    case (alu_op)
      4'd1:  {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      4'd3:  {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      4'd4:  alu_out = alu_a & alu_b;
      4'd8:  alu_out = alu_a | alu_b;
      4'd10: alu_out = {31'd0, alu_a == alu_b};
      4'd13: alu_out = ~alu_a;
      4'd15: alu_out = ~(alu_a | alu_b);
      default: ;
    endcase
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic run_prog(output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic read_reg(input logic [3:0] r, output logic [31:0] v);
    dbg_addr = r;
    #1 v = dbg_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err got %0b want 0", err); end
    n_checks++; if ({rom_en, rom_addr} !== 9'd0) begin n_fail++; $display("FAIL reset_rom got %0b/%0h want 0/0", rom_en, rom_addr); end
    n_checks++; if ({alu_op, alu_a, alu_b} !== 68'd0) begin n_fail++; $display("FAIL reset_alu got %0h/%0h/%0h want 0", alu_op, alu_a, alu_b); end
    n_checks++; if (carry_flag !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %0b want 0", carry_flag); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int cyc;
    logic [31:0] v;
    clear_rom();
    rom[0] = 16'h2105; rom[1] = 16'h2203; rom[2] = 16'h1312; rom[3] = 16'h0000;
    run_prog(cyc);
    // 2 + 2 + 3 + 3 cycles; done shows in the last of them.
    n_checks++; if (done !== 1'b1 || cyc !== 10) begin n_fail++; $display("FAIL add_done_latency got done=%0b cyc=%0d want 1/10", done, cyc); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_in_done got %0b want 1", busy); end
    read_reg(4'd3, v);
    n_checks++; if (v !== 32'd8) begin n_fail++; $display("FAIL add_r3 got %0h want 8", v); end
    n_checks++; if (carry_flag !== 1'b0) begin n_fail++; $display("FAIL add_carry got %0b want 0", carry_flag); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL add_err got %0b want 0", err); end
    @(negedge clk);
    n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL add_idle got done=%0b busy=%0b want 0/0", done, busy); end
  endtask

  task automatic test_sub_and();
    int cyc;
    logic [31:0] v;
    clear_rom();
    rom[0] = 16'h2105; rom[1] = 16'h2203; rom[2] = 16'h3412; rom[3] = 16'h4512;
    run_prog(cyc);
    n_checks++; if (done !== 1'b1 || cyc !== 13) begin n_fail++; $display("FAIL suband_latency got done=%0b cyc=%0d want 1/13", done, cyc); end
    read_reg(4'd4, v);
    n_checks++; if (v !== 32'd2) begin n_fail++; $display("FAIL sub_r4 got %0h want 2", v); end
    read_reg(4'd5, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL and_r5 got %0h want 1", v); end
    n_checks++; if (carry_flag !== 1'b1) begin n_fail++; $display("FAIL sub_and_carry got %0b want 1", carry_flag); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] v;
    logic [31:0] exp_v [4] = '{32'h0000_00FF, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h0000_01FE};
    clear_rom();
    rom[0] = 16'h210F; rom[1] = 16'h22F0; rom[2] = 16'h8612; rom[3] = 16'hF712;
    rom[4] = 16'hD810; rom[5] = 16'h1966; rom[6] = 16'hAA11;
    run_prog(cyc);
    n_checks++; if (done !== 1'b1 || cyc !== 22) begin n_fail++; $display("FAIL b2b_latency got done=%0b cyc=%0d want 1/22", done, cyc); end
    for (int i = 0; i < 4; i++) begin
      read_reg(4'(6 + i), v);
      n_checks++; if (v !== exp_v[i]) begin n_fail++; $display("FAIL b2b_r%0d got %0h want %0h", 6 + i, v, exp_v[i]); end
    end
    read_reg(4'd10, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL cmp_r10 got %0h want 1", v); end
    n_checks++; if (carry_flag !== 1'b0) begin n_fail++; $display("FAIL b2b_carry got %0b want 0", carry_flag); end
    @(negedge clk);
  endtask

  task automatic test_unsupported();
    int cyc;
    logic [31:0] v;
    clear_rom();
    rom[0] = 16'h6123;
    run_prog(cyc);
    n_checks++; if (done !== 1'b1 || cyc !== 5) begin n_fail++; $display("FAIL unsup_latency got done=%0b cyc=%0d want 1/5", done, cyc); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL unsup_err got %0b want 1", err); end
    read_reg(4'd1, v);
    n_checks++; if (v !== 32'h0F) begin n_fail++; $display("FAIL unsup_r1 got %0h want f", v); end
    @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL unsup_err_sticky got %0b want 1", err); end
    rom[0] = 16'h0000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_clears_err got err=%0b busy=%0b want 0/1", err, busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_r0();
    int cyc;
    logic [31:0] v;
    clear_rom();
    rom[0] = 16'h20FF;
    run_prog(cyc);
    read_reg(4'd0, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL r0_write got %0h want 0", v); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int cyc;
    logic [31:0] v;
    clear_rom();
    rom[0] = 16'h2105; rom[1] = 16'h2203; rom[2] = 16'h1312;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (alu_op !== 4'd1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (alu_op !== 4'd1 || alu_a !== 32'd5 || alu_b !== 32'd3) begin n_fail++; $display("FAIL abort_exec_reached got op=%0h a=%0h b=%0h want 1/5/3", alu_op, alu_a, alu_b); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, done, err, rom_en, rom_addr, alu_op, alu_a, alu_b, carry_flag} !== 81'd0) begin n_fail++; $display("FAIL abort_outputs got busy=%0b rom_en=%0b op=%0h a=%0h b=%0h want all 0", busy, rom_en, alu_op, alu_a, alu_b); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || rom_en !== 1'b0) begin n_fail++; $display("FAIL abort_stays_idle got busy=%0b rom_en=%0b want 0/0", busy, rom_en); end
    read_reg(4'd3, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL abort_r3 got %0h want 0", v); end
  endtask

  task automatic test_pc_wrap();
    int cyc;
    bit seen_top, wrapped;
    logic [31:0] v;
    for (int i = 0; i < 256; i++) rom[i] = {8'h21, 8'(i)};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    seen_top = 1'b0;
    wrapped = 1'b0;
    while (!wrapped && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (rom_en && rom_addr == 8'hFF) seen_top = 1'b1;
      else if (seen_top && rom_en && rom_addr == 8'h00) wrapped = 1'b1;
    end
    n_checks++; if (!wrapped) begin n_fail++; $display("FAIL wrap_fetch0 got wrapped=%0b cyc=%0d want 1", wrapped, cyc); end
    n_checks++; if (busy !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL wrap_status got busy=%0b err=%0b want 1/0", busy, err); end
    read_reg(4'd1, v);
    n_checks++; if (v !== 32'hFF) begin n_fail++; $display("FAIL wrap_r1 got %0h want ff", v); end
    repeat (2) @(negedge clk);
    read_reg(4'd1, v);
    n_checks++; if (v !== 32'h00) begin n_fail++; $display("FAIL wrap_r1_after got %0h want 0", v); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_and();
    test_back_to_back();
    test_unsupported();
    test_r0();
    test_abort();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
